// File: rtl/decode_stage.sv
// MIPS decode stage: one-entry registered output buffer with a valid/ready handshake,
// plus a busy counter that stalls HI/LO consumers while a mult/div is in flight.
module decode_stage #(
    parameter int unsigned MDU_LATENCY = 32,
    parameter int unsigned ENABLE_MDU  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        branch,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        alu_src,
    output logic        alu_shift_shamt,
    output logic        reg_write,
    output logic        jump,
    output logic        jump_reg,
    output logic        link,
    output logic        reg_dst,
    output logic [3:0]  alu_control,
    output logic [2:0]  branch_type,
    output logic [2:0]  load_type,
    output logic [1:0]  store_type,
    output logic        mdu_start,
    output logic [1:0]  mdu_op,
    output logic        hilo_read,
    output logic        hilo_sel,
    output logic        illegal,
    output logic        mdu_busy
);

    localparam int unsigned CNT_W  = 6;
    localparam logic        MDU_EN = (ENABLE_MDU != 0);

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_NOR  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_SRL  = 4'd11;
    localparam logic [3:0] ALU_LUI  = 4'd12;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BGEZ = 3'd1;
    localparam logic [2:0] BR_BGTZ = 3'd2;
    localparam logic [2:0] BR_BLEZ = 3'd3;
    localparam logic [2:0] BR_BLTZ = 3'd4;
    localparam logic [2:0] BR_BNE  = 3'd5;

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LBU = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;
    localparam logic [2:0] LD_LW  = 3'd4;

    localparam logic [1:0] ST_SB = 2'd0;
    localparam logic [1:0] ST_SH = 2'd1;
    localparam logic [1:0] ST_SW = 2'd2;

    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    typedef struct packed {
        logic       branch;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       alu_shift_shamt;
        logic       reg_write;
        logic       jump;
        logic       jump_reg;
        logic       link;
        logic       reg_dst;
        logic [3:0] alu_control;
        logic [2:0] branch_type;
        logic [2:0] load_type;
        logic [1:0] store_type;
        logic       mdu_start;
        logic [1:0] mdu_op;
        logic       hilo_read;
        logic       hilo_sel;
        logic       illegal;
    } ctl_t;

    function automatic ctl_t f_imm(input logic [3:0] alu);
        ctl_t c;
        c             = '0;
        c.alu_src     = 1'b1;
        c.reg_write   = 1'b1;
        c.alu_control = alu;
        return c;
    endfunction

    function automatic ctl_t f_load(input logic [2:0] lt);
        ctl_t c;
        c             = f_imm(ALU_ADD);
        c.mem_to_reg  = 1'b1;
        c.load_type   = lt;
        return c;
    endfunction

    function automatic ctl_t f_store(input logic [2:0] st_unused_hi, input logic [1:0] st);
        ctl_t c;
        c             = '0;
        c.mem_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = ALU_ADD;
        c.store_type  = st;
        c.illegal     = |st_unused_hi;
        return c;
    endfunction

    function automatic ctl_t f_branch(input logic [2:0] bt);
        ctl_t c;
        c             = '0;
        c.branch      = 1'b1;
        c.branch_type = bt;
        return c;
    endfunction

    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       unused_instr;

    assign op           = instr[31:26];
    assign rt           = instr[20:16];
    assign funct        = instr[5:0];
    assign unused_instr = ^{instr[25:21], instr[15:6]};

    ctl_t            entry_q, entry_d, dec;
    logic            valid_q, valid_d;
    logic [CNT_W-1:0] busy_q, busy_d;
    logic [3:0]      r_alu;
    logic            r_hit, r_shamt, bad;
    logic            hazard, accept, consume;

    // R-type ALU funct map
    always_comb begin
        r_alu   = ALU_NOP;
        r_hit   = 1'b1;
        r_shamt = 1'b0;
        case (funct)
            6'h20, 6'h21: r_alu = ALU_ADD;
            6'h22, 6'h23: r_alu = ALU_SUB;
            6'h24:        r_alu = ALU_AND;
            6'h25:        r_alu = ALU_OR;
            6'h26:        r_alu = ALU_XOR;
            6'h27:        r_alu = ALU_NOR;
            6'h2a:        r_alu = ALU_SLT;
            6'h2b:        r_alu = ALU_SLTU;
            6'h00:        begin r_alu = ALU_SLL; r_shamt = 1'b1; end
            6'h04:        r_alu = ALU_SLL;
            6'h03:        begin r_alu = ALU_SRA; r_shamt = 1'b1; end
            6'h07:        r_alu = ALU_SRA;
            6'h02:        begin r_alu = ALU_SRL; r_shamt = 1'b1; end
            6'h06:        r_alu = ALU_SRL;
            default:      r_hit = 1'b0;
        endcase
    end

    // Full instruction decode; anything unrecognised collapses to a bare illegal flag
    always_comb begin
        dec = '0;
        bad = 1'b0;
        case (op)
            6'h00: begin
                if (r_hit) begin
                    dec.reg_dst         = 1'b1;
                    dec.reg_write       = 1'b1;
                    dec.alu_control     = r_alu;
                    dec.alu_shift_shamt = r_shamt;
                end else begin
                    case (funct)
                        F_JR:   dec.jump_reg = 1'b1;
                        F_JALR: begin
                            dec.jump_reg  = 1'b1;
                            dec.link      = 1'b1;
                            dec.reg_write = 1'b1;
                            dec.reg_dst   = 1'b1;
                        end
                        F_MFHI, F_MFLO: begin
                            if (MDU_EN) begin
                                dec.hilo_read = 1'b1;
                                dec.hilo_sel  = (funct == F_MFHI);
                                dec.reg_dst   = 1'b1;
                                dec.reg_write = 1'b1;
                            end else begin
                                bad = 1'b1;
                            end
                        end
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            if (MDU_EN) begin
                                dec.mdu_start = 1'b1;
                                dec.mdu_op    = funct[1:0];
                            end else begin
                                bad = 1'b1;
                            end
                        end
                        default: bad = 1'b1;
                    endcase
                end
            end
            6'h01: begin
                if (rt == 5'd1)      dec = f_branch(BR_BGEZ);
                else if (rt == 5'd0) dec = f_branch(BR_BLTZ);
                else                 bad = 1'b1;
            end
            6'h02: dec.jump = 1'b1;
            6'h03: begin
                dec.jump      = 1'b1;
                dec.link      = 1'b1;
                dec.reg_write = 1'b1;
            end
            6'h04: dec = f_branch(BR_BEQ);
            6'h05: dec = f_branch(BR_BNE);
            6'h06: dec = f_branch(BR_BLEZ);
            6'h07: dec = f_branch(BR_BGTZ);
            6'h08, 6'h09: dec = f_imm(ALU_ADD);
            6'h0a: dec = f_imm(ALU_SLT);
            6'h0b: dec = f_imm(ALU_SLTU);
            6'h0c: dec = f_imm(ALU_AND);
            6'h0d: dec = f_imm(ALU_OR);
            6'h0e: dec = f_imm(ALU_XOR);
            6'h0f: dec = f_imm(ALU_LUI);
            6'h20: dec = f_load(LD_LB);
            6'h21: dec = f_load(LD_LH);
            6'h23: dec = f_load(LD_LW);
            6'h24: dec = f_load(LD_LBU);
            6'h25: dec = f_load(LD_LHU);
            6'h28: dec = f_store(3'd0, ST_SB);
            6'h29: dec = f_store(3'd0, ST_SH);
            6'h2b: dec = f_store(3'd0, ST_SW);
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // HI/LO users wait while a mult/div is held or still counting down
    assign hazard   = (dec.mdu_start | dec.hilo_read) &
                      ((busy_q != '0) | (valid_q & entry_q.mdu_start));
    assign in_ready = (~valid_q | out_ready) & ~flush & ~hazard;
    assign accept   = in_valid & in_ready;
    assign consume  = valid_q & out_ready & ~flush;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (flush) begin
            valid_d = 1'b0;
            entry_d = '0;
        end else if (accept) begin
            valid_d = 1'b1;
            entry_d = dec;
        end else if (consume) begin
            valid_d = 1'b0;
            entry_d = '0;
        end
    end

    // Busy counter: reload on handing a mult/div downstream, else count down to zero
    always_comb begin
        busy_d = busy_q;
        if (!MDU_EN) begin
            busy_d = '0;
        end else if (consume && entry_q.mdu_start) begin
            busy_d = CNT_W'(MDU_LATENCY);
        end else if (busy_q != '0) begin
            busy_d = busy_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            entry_q <= '0;
            busy_q  <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
            busy_q  <= busy_d;
        end
    end

    assign out_valid       = valid_q;
    assign branch          = entry_q.branch;
    assign mem_to_reg      = entry_q.mem_to_reg;
    assign mem_write       = entry_q.mem_write;
    assign alu_src         = entry_q.alu_src;
    assign alu_shift_shamt = entry_q.alu_shift_shamt;
    assign reg_write       = entry_q.reg_write;
    assign jump            = entry_q.jump;
    assign jump_reg        = entry_q.jump_reg;
    assign link            = entry_q.link;
    assign reg_dst         = entry_q.reg_dst;
    assign alu_control     = entry_q.alu_control;
    assign branch_type     = entry_q.branch_type;
    assign load_type       = entry_q.load_type;
    assign store_type      = entry_q.store_type;
    assign mdu_start       = entry_q.mdu_start;
    assign mdu_op          = entry_q.mdu_op;
    assign hilo_read       = entry_q.hilo_read;
    assign hilo_sel        = entry_q.hilo_sel;
    assign illegal         = entry_q.illegal;
    assign mdu_busy        = (busy_q != '0);

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scoreboard of expected control bundles,
// plus directed handshake, hazard, flush and reset scenarios.
module tb_decode_stage;

    localparam logic [9:0] F_BR  = 10'h200;
    localparam logic [9:0] F_MTR = 10'h100;
    localparam logic [9:0] F_MW  = 10'h080;
    localparam logic [9:0] F_SRC = 10'h040;
    localparam logic [9:0] F_SH  = 10'h020;
    localparam logic [9:0] F_RW  = 10'h010;
    localparam logic [9:0] F_J   = 10'h008;
    localparam logic [9:0] F_JR  = 10'h004;
    localparam logic [9:0] F_LNK = 10'h002;
    localparam logic [9:0] F_RD  = 10'h001;

    logic        clk;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [31:0] instr;

    logic        in_ready, out_valid, branch, mem_to_reg, mem_write, alu_src, alu_shift_shamt;
    logic        reg_write, jump, jump_reg, link, reg_dst, mdu_start, hilo_read, hilo_sel;
    logic        illegal, mdu_busy;
    logic [3:0]  alu_control;
    logic [2:0]  branch_type, load_type;
    logic [1:0]  store_type, mdu_op;

    logic        n_in_ready, n_out_valid, n_branch, n_mem_to_reg, n_mem_write, n_alu_src;
    logic        n_alu_shift_shamt, n_reg_write, n_jump, n_jump_reg, n_link, n_reg_dst;
    logic        n_mdu_start, n_hilo_read, n_hilo_sel, n_illegal, n_mdu_busy;
    logic [3:0]  n_alu_control;
    logic [2:0]  n_branch_type, n_load_type;
    logic [1:0]  n_store_type, n_mdu_op;

    logic [27:0] obs, n_obs, exp_cur;
    logic [27:0] sb_q[$];
    logic [31:0] tbl_i[$];
    logic [27:0] tbl_e[$];
    int          nb_plain;
    int          errors = 0;
    int          checks = 0;

    decode_stage #(.MDU_LATENCY(4), .ENABLE_MDU(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .branch(branch), .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
        .alu_shift_shamt(alu_shift_shamt), .reg_write(reg_write), .jump(jump),
        .jump_reg(jump_reg), .link(link), .reg_dst(reg_dst), .alu_control(alu_control),
        .branch_type(branch_type), .load_type(load_type), .store_type(store_type),
        .mdu_start(mdu_start), .mdu_op(mdu_op), .hilo_read(hilo_read), .hilo_sel(hilo_sel),
        .illegal(illegal), .mdu_busy(mdu_busy)
    );

    decode_stage #(.MDU_LATENCY(4), .ENABLE_MDU(0)) u_nomdu (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready), .instr(instr),
        .flush(flush), .out_valid(n_out_valid), .out_ready(out_ready),
        .branch(n_branch), .mem_to_reg(n_mem_to_reg), .mem_write(n_mem_write),
        .alu_src(n_alu_src), .alu_shift_shamt(n_alu_shift_shamt), .reg_write(n_reg_write),
        .jump(n_jump), .jump_reg(n_jump_reg), .link(n_link), .reg_dst(n_reg_dst),
        .alu_control(n_alu_control), .branch_type(n_branch_type), .load_type(n_load_type),
        .store_type(n_store_type), .mdu_start(n_mdu_start), .mdu_op(n_mdu_op),
        .hilo_read(n_hilo_read), .hilo_sel(n_hilo_sel), .illegal(n_illegal),
        .mdu_busy(n_mdu_busy)
    );

    assign obs = {branch, mem_to_reg, mem_write, alu_src, alu_shift_shamt, reg_write, jump,
                  jump_reg, link, reg_dst, alu_control, branch_type, load_type, store_type,
                  mdu_start, mdu_op, hilo_read, hilo_sel, illegal};
    assign n_obs = {n_branch, n_mem_to_reg, n_mem_write, n_alu_src, n_alu_shift_shamt,
                    n_reg_write, n_jump, n_jump_reg, n_link, n_reg_dst, n_alu_control,
                    n_branch_type, n_load_type, n_store_type, n_mdu_start, n_mdu_op,
                    n_hilo_read, n_hilo_sel, n_illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] mk(input logic [9:0] f, input logic [3:0] alu,
                                       input logic [2:0] bt, input logic [2:0] lt,
                                       input logic [1:0] st, input logic ms,
                                       input logic [1:0] mo, input logic hr,
                                       input logic hs, input logic il);
        return {f, alu, bt, lt, st, ms, mo, hr, hs, il};
    endfunction

    function automatic logic [27:0] e_alu(input logic [9:0] f, input logic [3:0] alu);
        return mk(f, alu, 3'd0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [27:0] e_br(input logic [2:0] bt);
        return mk(F_BR, 4'd0, bt, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [27:0] e_ld(input logic [2:0] lt);
        return mk(F_MTR | F_RW | F_SRC, 4'd1, 3'd0, lt, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [27:0] e_st(input logic [1:0] st);
        return mk(F_MW | F_SRC, 4'd1, 3'd0, 3'd0, st, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [27:0] e_mdu(input logic [1:0] mo);
        return mk(10'h0, 4'd0, 3'd0, 3'd0, 2'd0, 1'b1, mo, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [27:0] e_hilo(input logic hs);
        return mk(F_RW | F_RD, 4'd0, 3'd0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b1, hs, 1'b0);
    endfunction
    function automatic logic [27:0] e_ill();
        return mk(10'h0, 4'd0, 3'd0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    endfunction

    // Scoreboard: push on accept, pop/compare on consume, discard on flush
    always begin : sb_mon
        logic [27:0] e;
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (flush && out_valid) begin
                if (sb_q.size() > 0) void'(sb_q.pop_front());
            end else if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_consume: got %h with no entry expected at %0t", obs, $time);
                end else begin
                    e = sb_q.pop_front();
                    if (obs !== e) begin
                        errors++;
                        $display("FAIL sb_consume: got %h expected %h at %0t", obs, e, $time);
                    end
                end
            end
            if (in_valid && in_ready) sb_q.push_back(exp_cur);
        end
    end

    task automatic drive(input logic [31:0] i, input logic [27:0] e);
        in_valid = 1'b1;
        instr    = i;
        exp_cur  = e;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        instr    = 32'h0;
    endtask

    task automatic wait_idle();
        int n = 0;
        idle();
        out_ready = 1'b1;
        while ((mdu_busy || out_valid) && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mdu_busy || out_valid) begin
            errors++;
            $display("FAIL wait_idle: busy=%b valid=%b after %0d cycles", mdu_busy, out_valid, n);
        end
    endtask

    task automatic add_vec(input logic [31:0] i, input logic [27:0] e);
        tbl_i.push_back(i);
        tbl_e.push_back(e);
    endtask

    task automatic build_table();
        add_vec(32'h00851021, e_alu(F_RW | F_RD, 4'd1));
        add_vec(32'h00851020, e_alu(F_RW | F_RD, 4'd1));
        add_vec(32'h00851022, e_alu(F_RW | F_RD, 4'd2));
        add_vec(32'h00851023, e_alu(F_RW | F_RD, 4'd2));
        add_vec(32'h00851024, e_alu(F_RW | F_RD, 4'd3));
        add_vec(32'h00851025, e_alu(F_RW | F_RD, 4'd4));
        add_vec(32'h00851026, e_alu(F_RW | F_RD, 4'd5));
        add_vec(32'h00851027, e_alu(F_RW | F_RD, 4'd6));
        add_vec(32'h0085102a, e_alu(F_RW | F_RD, 4'd7));
        add_vec(32'h0085102b, e_alu(F_RW | F_RD, 4'd8));
        add_vec(32'h000510C0, e_alu(F_RW | F_RD | F_SH, 4'd9));
        add_vec(32'h00851004, e_alu(F_RW | F_RD, 4'd9));
        add_vec(32'h000510C3, e_alu(F_RW | F_RD | F_SH, 4'd10));
        add_vec(32'h00851007, e_alu(F_RW | F_RD, 4'd10));
        add_vec(32'h000510C2, e_alu(F_RW | F_RD | F_SH, 4'd11));
        add_vec(32'h00851006, e_alu(F_RW | F_RD, 4'd11));
        add_vec(32'h20A20010, e_alu(F_SRC | F_RW, 4'd1));
        add_vec(32'h24A20010, e_alu(F_SRC | F_RW, 4'd1));
        add_vec(32'h30A200FF, e_alu(F_SRC | F_RW, 4'd3));
        add_vec(32'h34A200FF, e_alu(F_SRC | F_RW, 4'd4));
        add_vec(32'h38A200FF, e_alu(F_SRC | F_RW, 4'd5));
        add_vec(32'h28A20001, e_alu(F_SRC | F_RW, 4'd7));
        add_vec(32'h2CA20001, e_alu(F_SRC | F_RW, 4'd8));
        add_vec(32'h3C021234, e_alu(F_SRC | F_RW, 4'd12));
        add_vec(32'h10850004, e_br(3'd0));
        add_vec(32'h14850004, e_br(3'd5));
        add_vec(32'h18800004, e_br(3'd3));
        add_vec(32'h1C800004, e_br(3'd2));
        add_vec(32'h04810004, e_br(3'd1));
        add_vec(32'h04800004, e_br(3'd4));
        add_vec(32'h81280004, e_ld(3'd0));
        add_vec(32'h91280004, e_ld(3'd1));
        add_vec(32'h85280004, e_ld(3'd2));
        add_vec(32'h95280004, e_ld(3'd3));
        add_vec(32'h8D280004, e_ld(3'd4));
        add_vec(32'hA1280004, e_st(2'd0));
        add_vec(32'hA5280004, e_st(2'd1));
        add_vec(32'hAD280004, e_st(2'd2));
        add_vec(32'h08000010, e_alu(F_J, 4'd0));
        add_vec(32'h0C000010, e_alu(F_J | F_LNK | F_RW, 4'd0));
        add_vec(32'h03E00008, e_alu(F_JR, 4'd0));
        add_vec(32'h0080F809, e_alu(F_JR | F_LNK | F_RW | F_RD, 4'd0));
        add_vec(32'hFC000000, e_ill());
        add_vec(32'h04020000, e_ill());
        add_vec(32'h00851001, e_ill());
        add_vec(32'h40000000, e_ill());
        nb_plain = tbl_i.size();
        add_vec(32'h00850018, e_mdu(2'd0));
        add_vec(32'h00850019, e_mdu(2'd1));
        add_vec(32'h0085001a, e_mdu(2'd2));
        add_vec(32'h0085001b, e_mdu(2'd3));
        add_vec(32'h00001010, e_hilo(1'b1));
        add_vec(32'h00001012, e_hilo(1'b0));
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        drive(32'h00851021, e_alu(F_RW | F_RD, 4'd1));
        repeat (2) @(negedge clk);
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        if (obs !== 28'h0) begin errors++; $display("FAIL reset_ctl: got %h expected 0", obs); end
        if (mdu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", mdu_busy); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        if (n_out_valid !== 1'b0) begin errors++; $display("FAIL reset_nomdu_valid: got %b expected 0", n_out_valid); end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_addu();
        logic [27:0] e;
        e = e_alu(F_RW | F_RD, 4'd1);
        out_ready = 1'b1;
        drive(32'h00851021, e);
        @(negedge clk);
        idle();
        #1;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL addu_valid: got %b expected 1", out_valid); end
        if (obs !== e) begin errors++; $display("FAIL addu_ctl: got %h expected %h", obs, e); end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL addu_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_load_hold();
        logic [27:0] e;
        e = e_ld(3'd4);
        out_ready = 1'b0;
        drive(32'h8D280004, e);
        @(negedge clk);
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL lw_hold_valid[%0d]: got %b expected 1", k, out_valid); end
            if (obs !== e) begin errors++; $display("FAIL lw_hold_ctl[%0d]: got %h expected %h", k, obs, e); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL lw_hold_in_ready[%0d]: got %b expected 0", k, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL lw_release_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lw_consumed: got %b expected 0", out_valid); end
    endtask

    task automatic test_decode_table();
        out_ready = 1'b1;
        for (int n = 0; n < nb_plain; n++) begin
            drive(tbl_i[n], tbl_e[n]);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL table_in_ready[%h]: got %b expected 1", tbl_i[n], in_ready);
            end
            @(negedge clk);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(32'hFC000000, e_ill());
        @(negedge clk);
        drive(32'h04020000, e_ill());
        #1;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL illegal_valid: got %b expected 1", out_valid); end
        if (obs !== e_ill()) begin errors++; $display("FAIL illegal_ctl_fc: got %h expected %h", obs, e_ill()); end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (obs !== e_ill()) begin errors++; $display("FAIL illegal_ctl_regimm: got %h expected %h", obs, e_ill()); end
        @(negedge clk);
    endtask

    task automatic test_mdu_hazard();
        wait_idle();
        drive(32'h00850018, e_mdu(2'd0));
        @(negedge clk);
        idle();
        @(negedge clk);
        drive(32'h00001012, e_hilo(1'b0));
        for (int k = 0; k < 4; k++) begin
            #1;
            checks += 2;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL mflo_stall_in_ready[%0d]: got %b expected 0", k, in_ready); end
            if (mdu_busy !== 1'b1) begin errors++; $display("FAIL mflo_stall_busy[%0d]: got %b expected 1", k, mdu_busy); end
            @(negedge clk);
        end
        #1;
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mflo_release_in_ready: got %b expected 1", in_ready); end
        if (mdu_busy !== 1'b0) begin errors++; $display("FAIL mflo_release_busy: got %b expected 0", mdu_busy); end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (obs !== e_hilo(1'b0)) begin errors++; $display("FAIL mflo_ctl: got %h expected %h", obs, e_hilo(1'b0)); end
        @(negedge clk);
    endtask

    task automatic test_nonmdu_during_busy();
        wait_idle();
        drive(32'h00850019, e_mdu(2'd1));
        @(negedge clk);
        drive(32'h00851021, e_alu(F_RW | F_RD, 4'd1));
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL nonmdu_held_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        drive(32'h00851022, e_alu(F_RW | F_RD, 4'd2));
        #1;
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL nonmdu_busy_in_ready: got %b expected 1", in_ready); end
        if (mdu_busy !== 1'b1) begin errors++; $display("FAIL nonmdu_busy_flag: got %b expected 1", mdu_busy); end
        @(negedge clk);
        wait_idle();
    endtask

    task automatic test_flush();
        wait_idle();
        out_ready = 1'b0;
        drive(32'h00850018, e_mdu(2'd0));
        @(negedge clk);
        drive(32'h00851021, e_alu(F_RW | F_RD, 4'd1));
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        flush = 1'b0;
        drive(32'h00001010, e_hilo(1'b1));
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        if (mdu_busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", mdu_busy); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_mfhi_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        idle();
        #1;
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_mfhi_valid: got %b expected 1", out_valid); end
        if (obs !== e_hilo(1'b1)) begin errors++; $display("FAIL flush_mfhi_ctl: got %h expected %h", obs, e_hilo(1'b1)); end
        if (mdu_busy !== 1'b0) begin errors++; $display("FAIL flush_busy_late: got %b expected 0", mdu_busy); end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        wait_idle();
        drive(32'h0085001a, e_mdu(2'd2));
        @(negedge clk);
        idle();
        @(negedge clk);
        drive(32'h00001010, e_hilo(1'b1));
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_pre_reset: got %b expected 0", in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (mdu_busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b expected 0", mdu_busy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready: got %b expected 1", in_ready); end
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_mfhi_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (obs !== e_hilo(1'b1)) begin errors++; $display("FAIL post_reset_mfhi_ctl: got %h expected %h", obs, e_hilo(1'b1)); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int  idx, waited;
        logic acc;
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, tbl_i.size() - 1);
            drive(tbl_i[idx], tbl_e[idx]);
            waited = 0;
            acc    = 1'b0;
            do begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                acc = in_ready;
                @(negedge clk);
                waited++;
            end while (!acc && waited < 40);
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL b2b_accept[%h]: not accepted after %0d cycles", tbl_i[idx], waited);
            end
        end
        wait_idle();
    endtask

    task automatic test_no_mdu();
        logic [27:0] ei;
        ei = e_ill();
        wait_idle();
        drive(32'h00850018, e_mdu(2'd0));
        @(negedge clk);
        drive(32'h00001010, e_hilo(1'b1));
        #1;
        checks += 5;
        if (n_out_valid !== 1'b1) begin errors++; $display("FAIL nomdu_valid: got %b expected 1", n_out_valid); end
        if (n_obs !== ei) begin errors++; $display("FAIL nomdu_mult_ctl: got %h expected %h", n_obs, ei); end
        if (n_mdu_start !== 1'b0) begin errors++; $display("FAIL nomdu_start: got %b expected 0", n_mdu_start); end
        if (n_in_ready !== 1'b1) begin errors++; $display("FAIL nomdu_no_hazard: got %b expected 1", n_in_ready); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mdu_held_hazard: got %b expected 0", in_ready); end
        @(negedge clk);
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (n_mdu_busy !== 1'b0) begin errors++; $display("FAIL nomdu_busy[%0d]: got %b expected 0", k, n_mdu_busy); end
            if (k == 0) begin
                checks++;
                if (n_obs !== ei) begin errors++; $display("FAIL nomdu_mfhi_ctl: got %h expected %h", n_obs, ei); end
            end
            @(negedge clk);
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        out_ready = 1'b1;
        exp_cur   = '0;
        build_table();
        test_reset();
        test_addu();
        test_load_hold();
        test_decode_table();
        test_illegal();
        test_mdu_hazard();
        test_nonmdu_during_busy();
        test_flush();
        test_reset_mid_stall();
        test_back_to_back();
        test_no_mdu();
        idle();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries never delivered, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
